// File: rtl/id_control_unit_pkg.sv
// Shared types and constants for the decode-stage control unit.
package id_control_unit_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_e;

  // Instruction class, instr[27:25]
  localparam logic [2:0] DP_REG = 3'b000;
  localparam logic [2:0] DP_IMM = 3'b001;
  localparam logic [2:0] LS_IMM = 3'b010;
  localparam logic [2:0] LS_REG = 3'b011;
  localparam logic [2:0] BRANCH = 3'b101;

  // Data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       pc_src;
    logic [1:0] status;   // [1] link, [0] set-flags
    alu_op_e    alu_op;
  } ctrl_t;

  function automatic alu_op_e dp_alu_op(input logic [3:0] opcode);
    alu_op_e op;
    case (opcode)
      OP_ADD:         op = ALU_ADD;
      OP_SUB, OP_CMP: op = ALU_SUB;
      OP_AND, OP_TST: op = ALU_AND;
      OP_ORR:         op = ALU_ORR;
      default:        op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_control_unit_if.sv
// Decode-stage bus: fetch/decode inputs, raw controls and registered ID/EX controls.
interface id_control_unit_if;
  logic [31:0] pc_current;
  logic [31:0] instruction;
  logic        nop_select;
  logic [31:0] pc_plus_4;
  logic        reg_write_enable;
  logic        mem_write_enable;
  logic        mem_to_reg_select;
  logic        alu_source_select;
  logic        pc_source_select;
  logic [1:0]  status_bits;
  logic [1:0]  alu_operation;
  logic        ex_reg_write_enable;
  logic        ex_mem_write_enable;
  logic        ex_mem_to_reg_select;
  logic        ex_alu_source_select;
  logic        ex_pc_source_select;
  logic [1:0]  ex_status_bits;
  logic [1:0]  ex_alu_operation;

  modport master (
    output pc_current, instruction, nop_select,
    input  pc_plus_4, reg_write_enable, mem_write_enable, mem_to_reg_select,
           alu_source_select, pc_source_select, status_bits, alu_operation,
           ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select,
           ex_alu_source_select, ex_pc_source_select, ex_status_bits, ex_alu_operation
  );

  modport slave (
    input  pc_current, instruction, nop_select,
    output pc_plus_4, reg_write_enable, mem_write_enable, mem_to_reg_select,
           alu_source_select, pc_source_select, status_bits, alu_operation,
           ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select,
           ex_alu_source_select, ex_pc_source_select, ex_status_bits, ex_alu_operation
  );
endinterface

// File: rtl/id_control_unit_adder.sv
// Sequential fetch address: PC + 4, wrapping modulo 2^32.
module pc_adder (
  input  logic [31:0] pc_i,
  output logic [31:0] pc_plus_4_o
);
  assign pc_plus_4_o = pc_i + 32'd4;
endmodule

// File: rtl/id_control_unit_control_unit.sv
// Instruction decoder: IF/ID word to raw datapath controls (condition field ignored).
module control_unit
  import id_control_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    // The all-zero word would otherwise decode as AND R0,R0,R0.
    if (instr_i != '0) begin
      case (instr_i[27:25])
        DP_REG, DP_IMM: begin
          ctrl_o.reg_write = (instr_i[24:23] != 2'b10);
          ctrl_o.alu_src   = instr_i[25];
          ctrl_o.status    = {1'b0, instr_i[20]};
          ctrl_o.alu_op    = dp_alu_op(instr_i[24:21]);
        end
        LS_IMM, LS_REG: begin
          ctrl_o.alu_src    = ~instr_i[25];
          ctrl_o.alu_op     = instr_i[23] ? ALU_ADD : ALU_SUB;
          ctrl_o.reg_write  = instr_i[20];
          ctrl_o.mem_to_reg = instr_i[20];
          ctrl_o.mem_write  = ~instr_i[20];
        end
        BRANCH: begin
          ctrl_o.pc_src    = 1'b1;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.reg_write = instr_i[24];
          ctrl_o.status    = {instr_i[24], 1'b0};
        end
        default: ctrl_o = '0;
      endcase
    end
  end
endmodule

// File: rtl/id_control_unit_cu_mux.sv
// Bubble mux: forces every control to zero when a bubble is requested.
module cu_mux
  import id_control_unit_pkg::*;
(
  input  ctrl_t ctrl_i,
  input  logic  nop_select_i,
  output ctrl_t ctrl_o
);
  assign ctrl_o = nop_select_i ? ctrl_t'('0) : ctrl_i;
endmodule

// File: rtl/id_control_unit.sv
// Decode-stage control: PC+4, instruction decode, bubble mux and ID/EX control register.
module id_control_unit
  import id_control_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  id_control_unit_if.slave bus
);
  ctrl_t raw_ctrl;
  ctrl_t mux_ctrl;
  ctrl_t ex_ctrl_q;
  ctrl_t ex_ctrl_d;

  pc_adder u_adder (
    .pc_i        (bus.pc_current),
    .pc_plus_4_o (bus.pc_plus_4)
  );

  control_unit u_decode (
    .instr_i (bus.instruction),
    .ctrl_o  (raw_ctrl)
  );

  cu_mux u_mux (
    .ctrl_i       (raw_ctrl),
    .nop_select_i (bus.nop_select),
    .ctrl_o       (mux_ctrl)
  );

  assign ex_ctrl_d = mux_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_ctrl_q <= '0;
    else       ex_ctrl_q <= ex_ctrl_d;
  end

  assign bus.reg_write_enable  = raw_ctrl.reg_write;
  assign bus.mem_write_enable  = raw_ctrl.mem_write;
  assign bus.mem_to_reg_select = raw_ctrl.mem_to_reg;
  assign bus.alu_source_select = raw_ctrl.alu_src;
  assign bus.pc_source_select  = raw_ctrl.pc_src;
  assign bus.status_bits       = raw_ctrl.status;
  assign bus.alu_operation     = raw_ctrl.alu_op;

  assign bus.ex_reg_write_enable  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_write_enable  = ex_ctrl_q.mem_write;
  assign bus.ex_mem_to_reg_select = ex_ctrl_q.mem_to_reg;
  assign bus.ex_alu_source_select = ex_ctrl_q.alu_src;
  assign bus.ex_pc_source_select  = ex_ctrl_q.pc_src;
  assign bus.ex_status_bits       = ex_ctrl_q.status;
  assign bus.ex_alu_operation     = ex_ctrl_q.alu_op;
endmodule

// File: tb/tb_id_control_unit.sv
// Self-checking bench for id_control_unit: directed vectors plus per-cycle model compare.
module tb_id_control_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  id_control_unit_if bus ();

  id_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control vector packing: {rw, mw, m2r, alu_src, pc_src, status[1:0], alu_op[1:0]}
  logic [8:0] raw_vec, ex_vec, exp_ex;
  assign raw_vec = {bus.reg_write_enable, bus.mem_write_enable, bus.mem_to_reg_select,
                    bus.alu_source_select, bus.pc_source_select, bus.status_bits, bus.alu_operation};
  assign ex_vec  = {bus.ex_reg_write_enable, bus.ex_mem_write_enable, bus.ex_mem_to_reg_select,
                    bus.ex_alu_source_select, bus.ex_pc_source_select, bus.ex_status_bits,
                    bus.ex_alu_operation};

  function automatic logic [8:0] model(input logic [31:0] w);
    int cls = int'(w[27:25]);
    int opc = int'(w[24:21]);
    int rw = 0, mw = 0, mr = 0, as = 0, ps = 0, st = 0, op = 0;
    if (w == 32'd0) return 9'd0;
    if (cls == 0 || cls == 1) begin
      rw = (opc >= 8 && opc <= 11) ? 0 : 1;
      as = cls;
      st = int'(w[20]);
      if (opc == 2 || opc == 10)      op = 1;
      else if (opc == 0 || opc == 8)  op = 2;
      else if (opc == 12)             op = 3;
      else                            op = 0;
    end else if (cls == 2 || cls == 3) begin
      as = 3 - cls;
      op = w[23] ? 0 : 1;
      if (w[20]) begin rw = 1; mr = 1; end
      else mw = 1;
    end else if (cls == 5) begin
      ps = 1; as = 1; op = 0;
      rw = int'(w[24]);
      st = w[24] ? 2 : 0;
    end
    return {rw[0], mw[0], mr[0], as[0], ps[0], st[1:0], op[1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Expected ID/EX register content: one-edge delay of the muxed model, async clear.
  always @(posedge clk or posedge reset) begin
    if (reset) exp_ex <= 9'd0;
    else       exp_ex <= bus.nop_select ? 9'd0 : model(bus.instruction);
  end
  initial exp_ex = 9'd0;

  always @(negedge clk) begin
    check("pc4_model", bus.pc_plus_4, bus.pc_current + 32'd4);
    check("raw_model", {23'd0, raw_vec}, {23'd0, model(bus.instruction)});
    check("ex_model",  {23'd0, ex_vec},  {23'd0, exp_ex});
  end

  typedef struct {
    logic [31:0] instr;
    logic        nop;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [8:0]  raw;
    logic [8:0]  ex;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'hE2110000, 1'b0, 32'h00000000, 32'h00000004, 9'b100100110, 9'b100100110}); // ANDS imm
    vecs.push_back('{32'hE0805183, 1'b0, 32'h0000000C, 32'h00000010, 9'b100000000, 9'b100000000}); // ADD reg
    vecs.push_back('{32'hE7D12000, 1'b0, 32'hFFFFFFFC, 32'h00000000, 9'b101000000, 9'b101000000}); // LDRB reg
    vecs.push_back('{32'hE58A5000, 1'b0, 32'h00000100, 32'h00000104, 9'b010100000, 9'b010100000}); // STR U=1
    vecs.push_back('{32'hE50A5000, 1'b0, 32'h00000104, 32'h00000108, 9'b010100001, 9'b010100001}); // STR U=0
    vecs.push_back('{32'h1AFFFFFD, 1'b0, 32'h00000108, 32'h0000010C, 9'b000110000, 9'b000110000}); // BNE
    vecs.push_back('{32'hDB000009, 1'b0, 32'h0000010C, 32'h00000110, 9'b100111000, 9'b100111000}); // BLLE
    vecs.push_back('{32'h00000000, 1'b0, 32'h00000110, 32'h00000114, 9'b000000000, 9'b000000000}); // NOP
    vecs.push_back('{32'hE1811002, 1'b0, 32'h00000114, 32'h00000118, 9'b100000011, 9'b100000011}); // ORR
    vecs.push_back('{32'hE3510005, 1'b0, 32'h00000118, 32'h0000011C, 9'b000100101, 9'b000100101}); // CMP imm
    vecs.push_back('{32'hE8BD8000, 1'b0, 32'h0000011C, 32'h00000120, 9'b000000000, 9'b000000000}); // LDM class
    vecs.push_back('{32'hDB000009, 1'b1, 32'h00000120, 32'h00000124, 9'b100111000, 9'b000000000}); // bubble BL
    vecs.push_back('{32'hE58A5000, 1'b1, 32'h00000124, 32'h00000128, 9'b010100000, 9'b000000000}); // bubble STR

    bus.pc_current  = 32'd0;
    bus.instruction = 32'd0;
    bus.nop_select  = 1'b0;
    #1 check("reset_ex", {23'd0, ex_vec}, 32'd0);
    check("model_pin_ands", {23'd0, model(32'hE2110000)}, {23'd0, 9'b100100110});
    check("model_pin_blle", {23'd0, model(32'hDB000009)}, {23'd0, 9'b100111000});

    @(negedge clk); #2 reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk); #2;
      bus.instruction = vecs[i].instr;
      bus.nop_select  = vecs[i].nop;
      bus.pc_current  = vecs[i].pc;
      #1;
      check($sformatf("raw_%0d", i), {23'd0, raw_vec}, {23'd0, vecs[i].raw});
      check($sformatf("pc4_%0d", i), bus.pc_plus_4, vecs[i].pc4);
      @(negedge clk); #1;
      check($sformatf("ex_%0d", i), {23'd0, ex_vec}, {23'd0, vecs[i].ex});
    end

    // Asynchronous reset mid-stream while ex_* holds the ANDS controls
    @(negedge clk); #2;
    bus.instruction = 32'hE2110000;
    bus.nop_select  = 1'b0;
    @(negedge clk); #1;
    check("ands_held", {23'd0, ex_vec}, {23'd0, 9'b100100110});
    #1 reset = 1'b1;
    #1 check("async_clear", {23'd0, ex_vec}, 32'd0);
    @(negedge clk); #1;
    check("reset_hold", {23'd0, ex_vec}, 32'd0);
    #1 reset = 1'b0;
    bus.instruction = 32'hDB000009;
    @(negedge clk); #1;
    check("post_reset_load", {23'd0, ex_vec}, {23'd0, 9'b100111000});

    @(negedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
